pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the five segment registers of the RISC-V pipeline (IF PC, ID, EX, MEM, WB). It generates per-stage stall/flush (en/clear) controls and runs the data-memory request/acknowledge handshake for the instruction in MEM. It also serialises CSR writes by draining them to WB, and keeps a stall-cycle counter and a sticky memory-timeout flag. Operand forwarding is out of scope; it lives in the separate forwarding unit.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states,
// CSR drain length and the per-stage stall/flush control vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    CSR_DRAIN = 2'd2
  } state_e;

  localparam int unsigned CSR_DRAIN_CYC = 2;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } ctrl_t;

  // While in reset every segment is cleared and nothing is held.
  localparam ctrl_t RESET_CTRL = 9'b00000_1111;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection and priority resolution of the
// per-stage stall/flush controls for the current controller state.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic        mem_timeout_hit,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        MemToRegE,
  input  logic        BrE,
  input  logic        JalD,
  input  logic        MemToRegM,
  input  logic [3:0]  MemWriteM,
  input  logic        dmem_ack,
  output logic        mem_acc,
  output ctrl_t       ctrl
);

  logic load_use;
  logic mem_stall;

  always_comb begin
    mem_acc   = MemToRegM | (|MemWriteM);
    load_use  = MemToRegE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    // An ack or a timeout releases MEM in the same cycle it is seen.
    mem_stall = ((state == RUN) & mem_acc) |
                ((state == MEM_WAIT) & ~dmem_ack & ~mem_timeout_hit);

    ctrl = '0;
    if (mem_stall) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (state == CSR_DRAIN) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (BrE) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (load_use) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (JalD) begin
      ctrl.flush_d = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush generation, data-memory
// handshake for MEM, CSR write serialisation, stall counter and timeout flag.
//
// state     | meaning
// RUN       | normal flow; issues dmem_req or enters CSR drain
// MEM_WAIT  | F..M frozen waiting for dmem_ack or timeout
// CSR_DRAIN | F/D held, bubbles into E until the CSR write reaches WB
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        MemToRegE,
  input  logic        CSRWriteE,
  input  logic        BrE,
  input  logic        JalD,
  input  logic        MemToRegM,
  input  logic [3:0]  MemWriteM,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [31:0] stall_cnt,
  output logic        mem_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state;
  logic [TO_W-1:0] wait_cnt;
  logic [1:0]      drain_cnt;
  logic            mem_acc;
  logic            timeout_hit;
  ctrl_t           ctrl;
  ctrl_t           ctrl_out;

  assign timeout_hit = (wait_cnt == TO_LAST);

  hazard_detect u_hazard_detect (
    .state           (state),
    .mem_timeout_hit (timeout_hit),
    .Rs1D            (Rs1D),
    .Rs2D            (Rs2D),
    .RdE             (RdE),
    .MemToRegE       (MemToRegE),
    .BrE             (BrE),
    .JalD            (JalD),
    .MemToRegM       (MemToRegM),
    .MemWriteM       (MemWriteM),
    .dmem_ack        (dmem_ack),
    .mem_acc         (mem_acc),
    .ctrl            (ctrl)
  );

  assign ctrl_out = rst_n ? ctrl : RESET_CTRL;
  assign dmem_req = rst_n & (state == RUN) & mem_acc;

  assign StallF = ctrl_out.stall_f;
  assign StallD = ctrl_out.stall_d;
  assign StallE = ctrl_out.stall_e;
  assign StallM = ctrl_out.stall_m;
  assign StallW = ctrl_out.stall_w;
  assign FlushD = ctrl_out.flush_d;
  assign FlushE = ctrl_out.flush_e;
  assign FlushM = ctrl_out.flush_m;
  assign FlushW = ctrl_out.flush_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (StallF) stall_cnt <= stall_cnt + 32'd1;
      case (state)
        RUN: begin
          if (mem_acc) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end else if (CSRWriteE) begin
            state     <= CSR_DRAIN;
            drain_cnt <= 2'(CSR_DRAIN_CYC);
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state <= RUN;
          end else if (timeout_hit) begin
            mem_err <= 1'b1;
            state   <= RUN;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        CSR_DRAIN: begin
          drain_cnt <= drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared each cycle against a behavioural model of the sequencing rules.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        MemToRegE, CSRWriteE, BrE, JalD, MemToRegM, dmem_ack;
  logic [3:0]  MemWriteM;
  logic        dmem_req;
  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic [31:0] stall_cnt;
  logic        mem_err;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemToRegE(MemToRegE), .CSRWriteE(CSRWriteE), .BrE(BrE), .JalD(JalD),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .FlushW(FlushW), .stall_cnt(stall_cnt), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: an access in flight with the number of stalled
  // cycles so far, the remaining CSR drain cycles, error flag, stall count.
  bit          m_busy;
  int          m_stalled;
  int          m_drain;
  bit          m_err;
  logic [31:0] m_scnt;

  // {req, SF, SD, SE, SM, SW, FD, FE, FM, FW} sampled before the edge
  logic [9:0]  smp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    rst_n = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0; MemToRegE = 0; CSRWriteE = 0;
    BrE = 0; JalD = 0; MemToRegM = 0; MemWriteM = '0; dmem_ack = 0;
  endtask

  task automatic cycle();
    logic [9:0] exp;
    bit memacc, lu, mstall, rel, tmo;
    #1;
    exp = '0;
    memacc = MemToRegM || (MemWriteM != 0);
    lu = MemToRegE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    tmo = m_busy && !dmem_ack && (m_stalled == TIMEOUT);
    rel = m_busy && (dmem_ack || m_stalled == TIMEOUT);
    mstall = (m_busy && !rel) || (!m_busy && m_drain == 0 && memacc);
    if (!rst_n) exp = 10'b0_00000_1111;
    else begin
      exp[9] = !m_busy && m_drain == 0 && memacc;
      if (mstall)            begin exp[8] = 1; exp[7] = 1; exp[6] = 1; exp[5] = 1; exp[0] = 1; end
      else if (m_drain > 0)  begin exp[8] = 1; exp[7] = 1; exp[2] = 1; end
      else if (BrE)          begin exp[3] = 1; exp[2] = 1; end
      else if (lu)           begin exp[8] = 1; exp[7] = 1; exp[2] = 1; end
      else if (JalD)         exp[3] = 1;
    end
    smp = {dmem_req, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW};
    chk("ctl", 32'(smp), 32'(exp));
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_stalled = 0; m_drain = 0; m_err = 0; m_scnt = '0;
    end else begin
      m_scnt = m_scnt + 32'(exp[8]);
      if (m_busy) begin
        if (rel) begin m_busy = 0; if (tmo) m_err = 1; end
        else m_stalled++;
      end else if (m_drain > 0) m_drain--;
      else if (memacc) begin m_busy = 1; m_stalled = 1; end
      else if (CSRWriteE) m_drain = 2;
    end
    @(negedge clk);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("mem_err", 32'(mem_err), 32'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int req_n, sf_n, fw_n, r;
    logic [31:0] s0;
    m_busy = 0; m_stalled = 0; m_drain = 0; m_err = 0; m_scnt = '0;
    idle();
    rst_n = 0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_ctl", 32'(smp), 32'h00F);
    chk("rst_scnt", stall_cnt, 32'd0);

    // load-use, then RdE=0 variant
    idle(); MemToRegE = 1; RdE = 5'd5; Rs1D = 5'd5;
    cycle();
    chk("lu_stall", 32'({smp[8], smp[7], smp[2]}), 32'h7);
    idle(); cycle();
    chk("lu_free", 32'(smp[8]), 32'd0);
    MemToRegE = 1; RdE = 5'd0; Rs1D = 5'd0;
    cycle();
    chk("lu_rd0", 32'(smp[8]), 32'd0);

    // store with ack three cycles after the request
    idle(); s0 = stall_cnt; req_n = 0; sf_n = 0; fw_n = 0;
    for (int i = 0; i < 4; i++) begin
      MemWriteM = 4'hF; dmem_ack = (i == 3);
      cycle();
      req_n += int'(smp[9]); sf_n += int'(smp[8]); fw_n += int'(smp[0]);
    end
    chk("st_req", 32'(req_n), 32'd1);
    chk("st_stallf", 32'(sf_n), 32'd3);
    chk("st_flushw", 32'(fw_n), 32'd3);
    chk("st_scnt", stall_cnt - s0, 32'd3);
    idle(); cycle();

    // timeout with ack held low, then a later access keeps mem_err set
    sf_n = 0;
    for (int i = 0; i < 5; i++) begin
      MemToRegM = 1; cycle(); sf_n += int'(smp[8]);
    end
    chk("to_stallf", 32'(sf_n), 32'(TIMEOUT));
    chk("to_err", 32'(mem_err), 32'd1);
    idle(); cycle();
    MemToRegM = 1; cycle(); dmem_ack = 1; cycle(); idle(); cycle();
    chk("to_sticky", 32'(mem_err), 32'd1);

    // CSR drain with JAL in ID
    idle(); CSRWriteE = 1; cycle();
    idle(); JalD = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("csr_hold", 32'({smp[8], smp[7], smp[3], smp[2]}), 32'hD);
    end
    cycle();
    chk("csr_done", 32'({smp[8], smp[3]}), 32'h1);

    // branch beats load-use; branch during memory stall
    idle(); BrE = 1; MemToRegE = 1; RdE = 5'd7; Rs2D = 5'd7;
    cycle();
    chk("br_lu", 32'({smp[8], smp[3], smp[2]}), 32'h3);
    idle(); BrE = 1; JalD = 1; MemToRegM = 1;
    cycle();
    chk("br_mem", 32'(smp[3:0]), 32'h1);
    idle(); dmem_ack = 1; cycle();

    // reset in the middle of a wait, late ack is ignored
    idle(); MemToRegM = 1; cycle(); cycle();
    rst_n = 0; cycle();
    chk("rw_req", 32'(smp[9]), 32'd0);
    idle(); dmem_ack = 1; cycle();
    chk("rw_ack", 32'({smp[9], smp[8]}), 32'd0);
    chk("rw_scnt", stall_cnt, 32'd0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n     = ($urandom_range(199) != 0);
      Rs1D      = 5'($urandom_range(3));
      Rs2D      = 5'($urandom_range(3));
      RdE       = 5'($urandom_range(3));
      MemToRegE = ($urandom_range(99) < 40);
      CSRWriteE = ($urandom_range(99) < 10);
      BrE       = ($urandom_range(99) < 15);
      JalD      = ($urandom_range(99) < 15);
      r         = int'($urandom_range(99));
      MemToRegM = (r < 8);
      MemWriteM = (r >= 8 && r < 15) ? 4'($urandom_range(15, 1)) : 4'h0;
      dmem_ack  = ($urandom_range(99) < 30);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
